// File: rtl/aes_dec_ctrl.sv
// AES-128 decrypt sequencer: request, key expansion, decrypt, result.
// Optional key reuse cache when AES_DEC_KEY_CACHE_EN is defined.
module aes_dec_ctrl #(
  parameter int KE_CYCLES   = 11,
  parameter int DEC_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_key,
  input  logic [127:0] req_cypherText,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_plainText,
  output logic         res_err,
  output logic         ke_en,
  output logic [127:0] input_key,
  output logic [3:0]   ke_round,
  input  logic [127:0] ke_round_key,
  output logic         d_en,
  output logic [127:0] d_cypherText,
  input  logic [3:0]   d_round,
  output logic [127:0] d_round_key,
  input  logic [127:0] d_plainText,
  input  logic         dn
);

  localparam int CMAX =
    (KE_CYCLES > DEC_TIMEOUT) ? KE_CYCLES : DEC_TIMEOUT;
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] KE_LAST  = CW'(KE_CYCLES - 1);
  localparam logic [CW-1:0] DEC_LAST = CW'(DEC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    KEXP,
    DEC,
    RESP
  } state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           accept;
  logic           hit;
  logic [127:0]   res_pt_d;
  logic           res_err_d;

  assign req_ready   = (state == IDLE);
  assign ke_en       = (state == KEXP);
  assign d_en        = (state == DEC);
  assign res_valid   = (state == RESP);
  assign ke_round    = d_round;
  assign d_round_key = ke_round_key;

`ifdef AES_DEC_KEY_CACHE_EN
  logic key_vld, key_vld_d;

  assign hit = key_vld && (req_key == input_key);

  always_comb begin
    key_vld_d = key_vld;
    if (state == IDLE && req_valid && !hit)
      key_vld_d = 1'b0;
    if (state == KEXP && cnt == KE_LAST)
      key_vld_d = 1'b1;
    if (state == DEC && !dn && cnt == DEC_LAST)
      key_vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) key_vld <= 1'b0;
    else     key_vld <= key_vld_d;
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    accept    = 1'b0;
    res_pt_d  = res_plainText;
    res_err_d = res_err;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = hit ? DEC : KEXP;
        end
      end
      KEXP: begin
        if (cnt == KE_LAST) begin
          cnt_d   = '0;
          state_d = DEC;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DEC: begin
        // dn beats the timeout when both land together
        if (dn) begin
          res_pt_d  = d_plainText;
          res_err_d = 1'b0;
          state_d   = RESP;
        end else if (cnt == DEC_LAST) begin
          res_pt_d  = '0;
          res_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      input_key     <= '0;
      d_cypherText  <= '0;
      res_plainText <= '0;
      res_err       <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      res_plainText <= res_pt_d;
      res_err       <= res_err_d;
      if (accept) begin
        input_key    <= req_key;
        d_cypherText <= req_cypherText;
      end
    end
  end

endmodule

// File: doc/aes_dec_ctrl.md
# aes_dec_ctrl

Sequencing controller for the AES-128 decryption datapath. It accepts decrypt requests over a valid/ready handshake and drives the `keyExpan` enable for a fixed expansion window. It then runs `decrypt`, routing its round index to `keyExpan` and the returned round key back. It captures the plaintext on `dn` and presents it over a valid/ready result handshake with a timeout error path.

## Interface
Parameters:
- `KE_CYCLES`, 11: cycles `ke_en` is held high before decryption starts.
- `DEC_TIMEOUT`, 64: maximum DEC cycles waiting for `dn` before an error result is issued.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller can accept a request. High only in IDLE.
- `req_key` input 128: cipher key.
- `req_cypherText` input 128: ciphertext block.
- `res_valid` output 1: result present.
- `res_ready` input 1: consumer accepts the result.
- `res_plainText` output 128: decrypted block, or 0 on error.
- `res_err` output 1: timeout flag, qualified by `res_valid`.
- `ke_en` output 1: enable to `keyExpan`.
- `input_key` output 128: key register feeding `keyExpan`.
- `ke_round` output 4: round index to `keyExpan`.
- `ke_round_key` input 128: round key from `keyExpan`.
- `d_en` output 1: enable to `decrypt`.
- `d_cypherText` output 128: ciphertext register feeding `decrypt`.
- `d_round` input 4: round index requested by `decrypt`.
- `d_round_key` output 128: round key to `decrypt`.
- `d_plainText` input 128: plaintext from `decrypt`.
- `dn` input 1: decrypt done.

## Operation
- States: IDLE, KEXP, DEC, RESP.
- IDLE:
  - `req_ready`=1.
  - When `req_valid` is high, register `req_key` into `input_key` and `req_cypherText` into `d_cypherText`, clear the counter, and go to KEXP.
- KEXP:
  - `ke_en`=1, `d_en`=0; the counter increments each cycle.
  - When the counter reaches `KE_CYCLES`-1, clear the counter and go to DEC.
- DEC:
  - `d_en`=1, `ke_en`=0; the counter increments each cycle.
  - When `dn`=1, register `d_plainText` into `res_plainText`, set `res_err`=0, and go to RESP.
  - Otherwise, when the counter reaches `DEC_TIMEOUT`-1, set `res_plainText`=0, set `res_err`=1, and go to RESP.
  - If `dn` arrives on the timeout cycle, it wins.
- RESP:
  - `res_valid`=1, with outputs held stable.
  - When `res_ready`=1, go to IDLE.
- Round routing is combinational in every state: `ke_round` = `d_round`, `d_round_key` = `ke_round_key`.
- Request fields are sampled only at acceptance. Later changes on `req_*` have no effect until the next acceptance.
- Counter width is clog2(max(`KE_CYCLES`, `DEC_TIMEOUT`)) bits; it never wraps past its terminal count.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `res_valid`=0, `res_err`=0, `res_plainText`=0, `ke_en`=0, `d_en`=0, `input_key`=0, `d_cypherText`=0, counter=0.
- With the request accepted on edge T:
  - `ke_en` is high during cycles T+1 .. T+`KE_CYCLES`.
  - `d_en` rises at T+`KE_CYCLES`+1.
- `dn` sampled high at edge D gives `res_valid`=1 from D+1. Minimum accept-to-result latency is `KE_CYCLES`+2 cycles.
- A result consumed at edge R gives `req_ready`=1 from R+1. There is no back-to-back accept on the consume edge.
- `ke_en` and `d_en` are never high in the same cycle. Both are low in IDLE and RESP.
- `rst` in any state returns to reset values on the next edge, and any in-flight result is discarded.
- `dn` outside DEC is ignored.

## Configuration
- `AES_DEC_KEY_CACHE_EN` defined:
  - A key-valid flag (reset 0) is set on each completed KEXP.
  - If a request's `req_key` equals `input_key` while the flag is set, IDLE goes straight to DEC, skipping KEXP. Minimum latency is then 2 cycles plus the decrypt time.
  - A timeout clears the flag.
- `AES_DEC_KEY_CACHE_EN` undefined: every request passes through KEXP, and there is no flag logic.

## Test plan
- Reset mid-DEC:
  - Stimulus: `rst`=1 for one cycle while DEC is active.
  - Required response: next cycle state=IDLE, `d_en`=0, `res_valid`=0, `req_ready`=1.
- FIPS-197 vector:
  - Stimulus: key `000102030405060708090a0b0c0d0e0f`, ciphertext `69c4e0d86a7b0430d8cdb78070b4c55a`.
  - Required response: `res_plainText`=`00112233445566778899aabbccddeeff`, `res_err`=0.
  - Required timing: `ke_en` is high for exactly 11 cycles before `d_en` rises.
- SP800-38A vector:
  - Stimulus: key `2b7e151628aed2a6abf7158809cf4f3c`, ciphertext `3ad77bb40d7a3660a89ecaf32466ef97`.
  - Required response: `res_plainText`=`6bc1bee22e409f96e93d7e117393172a`.
  - Stimulus: hold `res_ready`=0 for 5 cycles.
  - Required response: `res_valid` and `res_plainText` stay stable, and `req_ready` stays 0.
- Timeout:
  - Stimulus: stub `decrypt` so `dn` is never asserted.
  - Required response: `res_valid`=1 exactly `DEC_TIMEOUT` cycles after `d_en` rises, with `res_err`=1 and `res_plainText`=0.
- Key cache (`AES_DEC_KEY_CACHE_EN`):
  - Stimulus: two back-to-back requests with the same key.
  - Required response: the second request shows `ke_en`=0 throughout and `d_en`=1 one cycle after acceptance.
  - Stimulus: a third request with a different key.
  - Required response: it runs the full KEXP.
- Round routing:
  - Stimulus: during DEC, sweep `d_round` from 10 down to 0.
  - Required response: `ke_round` tracks it in the same cycle, and `d_round_key` equals `ke_round_key` in the same cycle.
